// File: rtl/avm_mem_tester_pkg.sv
// Shared types and constants for the Avalon-MM memory tester: FSM states, bus widths, LFSR taps.
package avm_mem_tester_pkg;

  localparam int AVM_AW = 19;
  localparam int AVM_DW = 32;

  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [AVM_DW-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WGAP,
    S_RD_INIT,
    S_RD,
    S_RWAIT,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/avm_mem_tester_pattern_gen.sv
// Test-pattern source: load latches seed/mode, step advances one word (seed+index or Galois LFSR).
// word is registered and valid the cycle after load; no backpressure, step is obeyed every cycle.
module avm_mem_tester_pattern_gen
  import avm_mem_tester_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [AVM_DW-1:0] seed,
  output logic [AVM_DW-1:0] word
);

  logic [AVM_DW-1:0] val_q, val_d;
  logic [AVM_DW-1:0] lfsr_next;
  logic              mode_q, mode_d;

  always_comb begin
    lfsr_next = {1'b0, val_q[AVM_DW-1:1]} ^ (val_q[0] ? LFSR_TAPS : '0);
    val_d     = val_q;
    mode_d    = mode_q;
    if (load) begin
      mode_d = mode;
      // an all-zero LFSR would lock up, so substitute 1
      val_d  = (mode && seed == '0) ? {{(AVM_DW-1){1'b0}}, 1'b1} : seed;
    end else if (step) begin
      val_d = mode_q ? lfsr_next : val_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      mode_q <= mode_d;
    end
  end

  assign word = val_q;

endmodule

// File: rtl/avm_mem_tester.sv
// Avalon-MM initiator that writes a pattern over a word range, reads it back and reports mismatches.
// Write slot ACCESS_GAP cycles, read slot READ_LATENCY+2 cycles; no waitrequest, fixed-timing slave assumed.
module avm_mem_tester
  import avm_mem_tester_pkg::*;
#(
  parameter int ACCESS_GAP   = 3,
  parameter int READ_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AVM_AW-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic              pattern_sel,
  input  logic [AVM_DW-1:0] seed,
  output logic [AVM_AW-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [AVM_DW-1:0] avm_writedata,
  input  logic [AVM_DW-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [AVM_AW-1:0] fail_addr,
  output logic [AVM_DW-1:0] fail_data
);

  localparam int GW = (ACCESS_GAP < 2) ? 1 : $clog2(ACCESS_GAP + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);

  state_t            state_q, state_d;
  logic [AVM_AW-1:0] base_q, base_d, addr_q, addr_d;
  logic [AVM_AW-1:0] fail_addr_q, fail_addr_d;
  logic [AVM_DW-1:0] seed_q, seed_d, rdata_q, rdata_d, fail_data_q, fail_data_d;
  logic [15:0]       wc_q, wc_d, idx_q, idx_d, err_q, err_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              mode_q, mode_d, pass_q, pass_d;

  logic              pg_load, pg_step, pg_mode;
  logic [AVM_DW-1:0] pg_seed, pattern;

  avm_mem_tester_pattern_gen u_pattern_gen (
    .clk  (clk),
    .rst  (reset),
    .load (pg_load),
    .step (pg_step),
    .mode (pg_mode),
    .seed (pg_seed),
    .word (pattern)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    wc_d        = wc_q;
    idx_d       = idx_q;
    err_d       = err_q;
    gap_d       = gap_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pg_load     = 1'b0;
    pg_step     = 1'b0;
    pg_mode     = mode_q;
    pg_seed     = seed_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = {base_addr[AVM_AW-1:2], 2'b00};
          addr_d      = {base_addr[AVM_AW-1:2], 2'b00};
          seed_d      = seed;
          mode_d      = pattern_sel;
          wc_d        = word_count;
          idx_d       = '0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = (word_count == '0);
          pg_load     = 1'b1;
          pg_mode     = pattern_sel;
          pg_seed     = seed;
          state_d     = (word_count == '0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        pg_step = 1'b1;
        addr_d  = addr_q + AVM_AW'(4);
        idx_d   = idx_q + 1'b1;
        gap_d   = GW'(1);
        if (ACCESS_GAP > 1) state_d = S_WGAP;
        else                state_d = (idx_d == wc_q) ? S_RD_INIT : S_WR;
      end
      S_WGAP: begin
        if (gap_q == GW'(ACCESS_GAP - 1)) state_d = (idx_q == wc_q) ? S_RD_INIT : S_WR;
        else                              gap_d   = gap_q + 1'b1;
      end
      S_RD_INIT: begin
        // replay the identical sequence for the read-back phase
        addr_d  = base_q;
        idx_d   = '0;
        pg_load = 1'b1;
        state_d = S_RD;
      end
      S_RD: begin
        lat_d   = LW'(1);
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (lat_q == LW'(READ_LATENCY)) begin
          rdata_d = avm_readdata;
          state_d = S_CMP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_CMP: begin
        if (rdata_q != pattern) begin
          if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_addr_d = addr_q;
            fail_data_d = rdata_q;
          end
        end
        pg_step = 1'b1;
        addr_d  = addr_q + AVM_AW'(4);
        idx_d   = idx_q + 1'b1;
        if (idx_d == wc_q) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      seed_q      <= '0;
      mode_q      <= 1'b0;
      wc_q        <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      gap_q       <= '0;
      lat_q       <= '0;
      rdata_q     <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      wc_q        <= wc_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
      lat_q       <= lat_d;
      rdata_q     <= rdata_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Bus outputs decode straight from state so reset clears them without waiting for a clock
  assign avm_write      = (state_q == S_WR);
  assign avm_read       = (state_q == S_RD);
  assign avm_address    = (avm_write || avm_read) ? addr_q : '0;
  assign avm_byteenable = (avm_write || avm_read) ? 4'b1111 : 4'b0000;
  assign avm_writedata  = avm_write ? pattern : '0;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_addr      = fail_addr_q;
  assign fail_data      = fail_data_q;

endmodule

// File: tb/tb_avm_mem_tester.sv
// Directed bench: Avalon commands and end-of-test results are queued as expectations and checked by monitors.
module tb_avm_mem_tester;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [18:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        pattern_sel = 1'b0;
  logic [31:0] seed = '0;
  logic [18:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [18:0] fail_addr;
  logic [31:0] fail_data;

  avm_mem_tester #(.ACCESS_GAP(3), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .pattern_sel(pattern_sel), .seed(seed),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // 7-bit word-indexed memory model with fixed read latency; optional read corruption
  logic [31:0] mem [0:127];
  logic [6:0]  rd_idx = '0;
  logic [18:0] rd_addr = '0;
  int          rd_cnt = 0;
  logic        inj_en = 1'b0;
  logic [18:0] inj_addr = '0;

  always @(posedge clk) begin
    if (avm_write && avm_byteenable == 4'hF) mem[avm_address[8:2]] <= avm_writedata;
    if (avm_read) begin
      rd_idx  <= avm_address[8:2];
      rd_addr <= avm_address;
      rd_cnt  <= 1;
    end else if (rd_cnt != 0 && rd_cnt < 15) begin
      rd_cnt <= rd_cnt + 1;
    end
  end

  assign avm_readdata = (rd_cnt != RL) ? 32'hBADB_AD00 :
                        (inj_en && rd_addr == inj_addr) ? 32'h0 : mem[rd_idx];

  typedef struct { logic wr; logic [18:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { logic p; logic [15:0] e; logic [18:0] fa; logic [31:0] fd; } res_t;
  cmd_t exp_q[$];
  res_t res_q[$];
  cmd_t ec;
  res_t er;

  int   done_cnt = 0;
  int   done_cyc = 0;
  logic wr_seen = 1'b0;
  int   last_wr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) wr_seen = 1'b0;
      if (avm_write || avm_read) begin
        chk("cmd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ec = exp_q.pop_front();
          chk("cmd_kind", avm_write, ec.wr);
          chk("cmd_addr", avm_address, ec.addr);
          chk("cmd_be", avm_byteenable, 4'hF);
          if (ec.wr) chk("wr_data", avm_writedata, ec.data);
        end
      end
      if (avm_write) begin
        if (wr_seen) chk("write_gap", cyc - last_wr, 3);
        wr_seen = 1'b1;
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("result_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          er = res_q.pop_front();
          chk("pass", pass, er.p);
          chk("err_count", err_count, er.e);
          chk("fail_addr", fail_addr, er.fa);
          chk("fail_data", fail_data, er.fd);
        end
      end
    end
  end

  task automatic push_wr(input logic [18:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = 1'b1; c.addr = a; c.data = d;
    exp_q.push_back(c);
  endtask

  task automatic push_rd(input logic [18:0] a);
    cmd_t c;
    c.wr = 1'b0; c.addr = a; c.data = '0;
    exp_q.push_back(c);
  endtask

  task automatic push_res(input logic p, input logic [15:0] e, input logic [18:0] fa, input logic [31:0] fd);
    res_t r;
    r.p = p; r.e = e; r.fa = fa; r.fd = fd;
    res_q.push_back(r);
  endtask

  // Pulse start, scramble the inputs afterwards, wait (bounded) for exactly one done pulse
  task automatic run(input logic [18:0] b, input logic [15:0] n, input logic m,
                     input logic [31:0] s, output int start_c);
    int d0;
    int t;
    @(posedge clk); #1;
    base_addr = b; word_count = n; pattern_sel = m; seed = s; start = 1'b1;
    start_c = cyc;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 19'h55554; word_count = 16'd7; pattern_sel = ~m; seed = 32'hA5A5_5A5A;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = ~n[31]; n[21] = ~n[21]; n[1] = ~n[1]; n[0] = ~n[0];
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    logic [31:0] d;
    logic [31:0] lf_tab [0:5];
    logic [18:0] addrs4 [0:3];
    lf_tab[0] = 32'h0000_0001; lf_tab[1] = 32'h8020_0003; lf_tab[2] = 32'hC030_0002;
    lf_tab[3] = 32'h6018_0001; lf_tab[4] = 32'hB02C_0003; lf_tab[5] = 32'hD836_0002;
    addrs4[0] = 19'h7FFF8; addrs4[1] = 19'h7FFFC; addrs4[2] = 19'h00000; addrs4[3] = 19'h00004;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_be", avm_byteenable, 0);
    rst = 1'b0;

    // 1: incrementing pattern from DEAD0000
    for (int i = 0; i < 4; i++) push_wr(19'(4 * i), 32'hDEAD_0000 + i);
    for (int i = 0; i < 4; i++) push_rd(19'(4 * i));
    push_res(1'b1, 16'd0, 19'd0, 32'd0);
    run(19'h0, 16'd4, 1'b0, 32'hDEAD_0000, sc);

    // 2: word at 0x8 reads back as zero
    inj_en = 1'b1; inj_addr = 19'h8;
    for (int i = 0; i < 4; i++) push_wr(19'(4 * i), 32'hDEAD_0000 + i);
    for (int i = 0; i < 4; i++) push_rd(19'(4 * i));
    push_res(1'b0, 16'd1, 19'h8, 32'h0);
    run(19'h0, 16'd4, 1'b0, 32'hDEAD_0000, sc);
    inj_en = 1'b0;

    // 3: LFSR with zero seed
    d = lf_tab[5];
    for (int i = 0; i < 16; i++) begin
      if (i < 6) push_wr(19'h100 + 19'(4 * i), lf_tab[i]);
      else begin
        d = lfsr(d);
        push_wr(19'h100 + 19'(4 * i), d);
      end
    end
    for (int i = 0; i < 16; i++) push_rd(19'h100 + 19'(4 * i));
    push_res(1'b1, 16'd0, 19'd0, 32'd0);
    run(19'h100, 16'd16, 1'b1, 32'h0, sc);

    // 4: address wrap; low address bits must be ignored
    for (int i = 0; i < 4; i++) push_wr(addrs4[i], 32'h1234_5678 + i);
    for (int i = 0; i < 4; i++) push_rd(addrs4[i]);
    push_res(1'b1, 16'd0, 19'd0, 32'd0);
    run(19'h7FFFB, 16'd4, 1'b0, 32'h1234_5678, sc);

    // 5: empty range
    push_res(1'b1, 16'd0, 19'd0, 32'd0);
    run(19'h40, 16'd0, 1'b0, 32'h1, sc);
    chk("zero_done_latency", done_cyc - sc, 1);

    // 6: reset mid write phase, with a spurious start while busy
    for (int i = 0; i < 16; i++) push_wr(19'h200 + 19'(4 * i), 32'h0000_0100 + i);
    @(posedge clk); #1;
    base_addr = 19'h200; word_count = 16'd16; pattern_sel = 1'b0; seed = 32'h100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    base_addr = 19'h300; seed = 32'hFFFF_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("busy_before_reset", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_write", avm_write, 0);
    chk("arst_read", avm_read, 0);
    chk("arst_addr", avm_address, 0);
    chk("arst_wdata", avm_writedata, 0);
    chk("arst_be", avm_byteenable, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err_count, 0);
    chk("arst_fail_addr", fail_addr, 0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    res_q.delete();
    #1;
    rst = 1'b0;

    // recovery after reset
    for (int i = 0; i < 2; i++) push_wr(19'h20 + 19'(4 * i), 32'hCAFE_0000 + i);
    for (int i = 0; i < 2; i++) push_rd(19'h20 + 19'(4 * i));
    push_res(1'b1, 16'd0, 19'd0, 32'd0);
    run(19'h20, 16'd2, 1'b0, 32'hCAFE_0000, sc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
